// File: rtl/mac32_arbiter.sv
// Round-robin arbiter and issue sequencer sharing one FP32 multiply-add datapath
// between NUM_REQ requesters; tags each issued op and routes the result back.
module mac32_arbiter #(
    parameter int PARM_XLEN   = 32,
    parameter int NUM_REQ     = 4,
    parameter int MAC_LATENCY = 3,
    localparam int TAG_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*PARM_XLEN-1:0]   req_A_i,
    input  logic [NUM_REQ*PARM_XLEN-1:0]   req_B_i,
    input  logic [NUM_REQ*PARM_XLEN-1:0]   req_C_i,
    output logic                           mac_valid_o,
    output logic [PARM_XLEN-1:0]           mac_A_o,
    output logic [PARM_XLEN-1:0]           mac_B_o,
    output logic [PARM_XLEN-1:0]           mac_C_o,
    input  logic                           mac_valid_i,
    input  logic [PARM_XLEN-1:0]           mac_result_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [PARM_XLEN-1:0]           rsp_result_o,
    output logic                           idle_o,
    output logic                           err_o
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   grant_en;
    logic [TAG_W-1:0]       rr_ptr;
    logic [TAG_W-1:0]       grant_idx;
    logic                   grant_found;
    logic [NUM_REQ-1:0]     grant_oh;
    logic                   hs;

    logic                   vld_p0;
    logic [PARM_XLEN-1:0]   a_p0;
    logic [PARM_XLEN-1:0]   b_p0;
    logic [PARM_XLEN-1:0]   c_p0;

    logic [MAC_LATENCY:0]   tag_vld_p;
    logic [TAG_W-1:0]       tag_p [MAC_LATENCY+1];

    logic [NUM_REQ-1:0]     rsp_vld_p2;
    logic [PARM_XLEN-1:0]   rsp_res_p2;
    logic                   err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN blocks grants while the tag pipeline keeps shifting; en_i re-enters RUN at once.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            RUN: begin
                grant_en = en_i;
                if (!en_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                grant_en = en_i;
                if (en_i) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        grant_oh    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
        if (grant_found && grant_en && !rst) grant_oh[grant_idx] = 1'b1;
    end

    assign req_ready_o = grant_oh;
    assign hs          = |(req_valid_i & grant_oh);

    // Issue stage: operands captured from the granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= '0;
            rr_ptr <= '0;
        end else begin
            vld_p0 <= hs;
            if (hs) begin
                a_p0   <= req_A_i[int'(grant_idx)*PARM_XLEN +: PARM_XLEN];
                b_p0   <= req_B_i[int'(grant_idx)*PARM_XLEN +: PARM_XLEN];
                c_p0   <= req_C_i[int'(grant_idx)*PARM_XLEN +: PARM_XLEN];
                rr_ptr <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
            end
        end
    end

    assign mac_valid_o = vld_p0;
    assign mac_A_o     = a_p0;
    assign mac_B_o     = b_p0;
    assign mac_C_o     = c_p0;

    // Tag stage: the head entry lines up with the cycle the MAC result is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
            for (int i = 0; i <= MAC_LATENCY; i++) tag_p[i] <= '0;
        end else begin
            tag_vld_p[0] <= hs;
            tag_p[0]     <= hs ? grant_idx : '0;
            for (int i = 1; i <= MAC_LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_p[i]     <= tag_p[i-1];
            end
        end
    end

    // Return stage: a result is only forwarded when the tag pipeline expects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_p2 <= '0;
            rsp_res_p2 <= '0;
            err_q      <= 1'b0;
        end else begin
            if (mac_valid_i && tag_vld_p[MAC_LATENCY]) begin
                rsp_vld_p2 <= NUM_REQ'(1) << tag_p[MAC_LATENCY];
                rsp_res_p2 <= mac_result_i;
            end else begin
                rsp_vld_p2 <= '0;
            end
            if (mac_valid_i != tag_vld_p[MAC_LATENCY]) err_q <= 1'b1;
        end
    end

    assign rsp_valid_o  = rsp_vld_p2;
    assign rsp_result_o = rsp_res_p2;
    assign err_o        = err_q;
    assign idle_o       = !hs && !(|tag_vld_p) && !(|rsp_vld_p2);

endmodule

// File: doc/mac32_arbiter.md
# mac32_arbiter

Round-robin arbiter and issue sequencer that shares one FP32 fused multiply-add datapath (Result = A + B*C) between NUM_REQ requesters. Accepts operand triples over per-requester valid/ready handshakes, issues at most one operation per cycle to the MAC, and tracks each in-flight operation's requester tag through the MAC's fixed pipeline latency. Routes each result back to its originating requester. Sits between the requester agents/cores and the mac32 datapath; the scoreboard observes the MAC side unchanged.

## Interface
- PARM_XLEN, 32, operand/result width
- NUM_REQ, 4, number of requesters (2..8)
- MAC_LATENCY, 3, cycles from mac_valid_o high to matching mac_valid_i high (fixed, ≥1)
- TAG_W, $clog2(NUM_REQ), derived; not overridden

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_i  in  1  grant enable; 0 = stop accepting, drain in-flight ops
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_A_i / req_B_i / req_C_i  in  NUM_REQ*PARM_XLEN each  flattened operands; requester i at bits [i*XLEN +: XLEN]
- mac_valid_o  out  1  issue strobe to MAC
- mac_A_o / mac_B_o / mac_C_o  out  PARM_XLEN each  registered operands to MAC
- mac_valid_i  in  1  MAC result valid
- mac_result_i  in  PARM_XLEN  MAC result
- rsp_valid_o  out  NUM_REQ  one-hot response strobe
- rsp_result_o  out  PARM_XLEN  response data, qualified by rsp_valid_o
- idle_o  out  1  no request accepted and no op in flight
- err_o  out  1  sticky: mac_valid_i disagreed with tag pipeline

## Operation
- Grant: when en_i=1, req_ready_o[g]=1 for exactly one g: first i with req_valid_i[i]=1 searching from rr_ptr upward, wrapping NUM_REQ-1→0. Combinational from req_valid_i, rr_ptr, en_i. en_i=0 or no valid → req_ready_o=0.
- Handshake = req_valid_i[g] & req_ready_o[g]. On handshake: capture requester g's operands into mac_*_o; mac_valid_o=1 next cycle; push {1, g} into tag pipeline; rr_ptr ← (g+1) mod NUM_REQ.
- No handshake: mac_valid_o=0 next cycle; mac_*_o hold last values; rr_ptr holds; push {0, 0}.
- Tag pipeline: MAC_LATENCY+1 stage shift register of {v, tag}, aligned so head v=1 exactly in the cycle mac_valid_i is due.
- Return: mac_valid_i=1 and head v=1 → next cycle rsp_valid_o = one-hot(head tag), rsp_result_o = mac_result_i; else rsp_valid_o=0, rsp_result_o holds.
- Mismatch: mac_valid_i ≠ head v → err_o←1 (sticky until rst); spurious result dropped; missing result produces no response.
- No response backpressure; requesters accept rsp in the cycle presented.
- Two-state FSM: RUN (en_i=1, grants allowed) and DRAIN (en_i=0, no grants, pipeline shifts). DRAIN→RUN as soon as en_i=1. idle_o=1 when no handshake this cycle, tag pipeline all v=0, no rsp pending.
- Requester stalls with req_valid_i held and operands stable until ready; lowering valid without handshake is legal.

## Timing
- Throughput: one op/cycle sustained; any single requester gets ≥1 grant every NUM_REQ cycles while valid.
- Latency: handshake cycle t → mac_valid_o at t+1 → mac_valid_i at t+1+MAC_LATENCY → rsp_valid_o at t+2+MAC_LATENCY.
- Responses to a requester return in its issue order (fixed latency).
- Reset values: req_ready_o=0 during rst, mac_valid_o=0, mac_*_o=0, rsp_valid_o=0, rsp_result_o=0, err_o=0, idle_o=1, rr_ptr=0, FSM=RUN, tag pipeline cleared.
- Reset mid-operation: in-flight ops discarded, no responses; MAC shares rst and flushes, so no err_o after reset.
- en_i falling in cycle with handshake pending: no grant that cycle; ops already accepted complete normally.

## Test plan
- Single op: req 0 A=0x3f800000, B=0x40000000, C=0x40400000 at t → mac_valid_o at t+1, rsp_valid_o=4'b0001, rsp_result_o=0x40e00000 at t+2+MAC_LATENCY.
- All 4 requesters valid continuously, 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; responses one-hot in same order, back-to-back.
- Requesters 1 and 3 valid only, rr_ptr=2 → grant 3 then 1 then 3; requester 1 with A=0, B=0x3fc00000, C=0x40000000 receives 0x40400000.
- en_i=0 with 3 ops in flight → req_ready_o=0, 3 responses still delivered, idle_o=1 one cycle after last rsp; en_i=1 resumes grants at rr_ptr.
- Inject mac_valid_i=1 with empty pipeline → no rsp_valid_o, err_o=1 and stays 1 until rst.
- Assert rst mid-burst with 2 ops in flight → all outputs reset values next cycle, no responses, err_o=0, next grant to requester 0.
